// File: rtl/regfile_write_arbiter.sv
// Register file write-port arbiter: core writeback vs. debug/loader, with a post-reset clearing sweep.
// Define RF_INIT_SWEEP_EN to enable the x1..x(NUM_REGS-1) sweep; otherwise RUN is entered straight from reset.
module regfile_write_arbiter #(
  parameter int NUM_REGS     = 32,
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int INIT_VALUE   = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_waddr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic              core_stall,
  output logic              init_done,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  typedef enum logic {INIT, RUN} state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam logic [3:0]        LIMIT     = 4'(STARVE_LIMIT);
  localparam logic [DATA_W-1:0] INIT_VAL  = DATA_W'(INIT_VALUE);

`ifdef RF_INIT_SWEEP_EN
  localparam state_e RST_STATE = INIT;
`else
  localparam state_e RST_STATE = RUN;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic [3:0]        starve_q, starve_d;
  logic              ack_q, ack_d;
  logic              done_q, done_d;

  logic core_eff, dbg_ok, force_dbg, dbg_grant;

  assign core_eff  = core_we && (core_waddr != '0);
  assign dbg_ok    = dbg_req && !ack_q;
  assign force_dbg = dbg_ok && (starve_q == LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RST_STATE;
      sweep_q  <= ADDR_W'(1);
      starve_q <= '0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      starve_q <= starve_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    starve_d   = starve_q;
    ack_d      = 1'b0;
    done_d     = done_q;
    dbg_grant  = 1'b0;
    rf_we      = 1'b0;
    rf_waddr   = core_waddr;
    rf_wdata   = core_wdata;
    core_stall = 1'b0;
    case (state_q)
      INIT: begin
        rf_we      = 1'b1;
        rf_waddr   = sweep_q;
        rf_wdata   = INIT_VAL;
        core_stall = 1'b1;
        starve_d   = '0;
        sweep_d    = sweep_q + ADDR_W'(1);
        if (sweep_q == LAST_ADDR) begin
          state_d = RUN;
          done_d  = 1'b1;
        end
      end
      default: begin
        dbg_grant  = dbg_ok && (!core_eff || force_dbg);
        ack_d      = dbg_grant;
        core_stall = dbg_grant && core_eff;
        if (dbg_grant) begin
          rf_we    = (dbg_addr != '0);
          rf_waddr = dbg_addr;
          rf_wdata = dbg_wdata;
        end else if (core_eff) begin
          rf_we = 1'b1;
        end
        // Starvation count holds during the ack cycle (request still high but not eligible).
        if (dbg_grant || !dbg_req)   starve_d = '0;
        else if (dbg_ok && starve_q != LIMIT) starve_d = starve_q + 4'd1;
      end
    endcase
    if (!reset) begin
      rf_we      = 1'b0;
      core_stall = 1'b1;
    end
  end

  assign dbg_ack = ack_q;
`ifdef RF_INIT_SWEEP_EN
  assign init_done = done_q;
`else
  assign init_done = reset;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed-vector bench for regfile_write_arbiter; inputs driven on negedge, outputs checked 1ns later.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        core_we = 1'b0;
  logic [4:0]  core_waddr = '0;
  logic [31:0] core_wdata = '0;
  logic        dbg_req = 1'b0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_ack, core_stall, init_done, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_chk = 0;
  int n_pass = 0;

  regfile_write_arbiter dut (
    .clk(clk), .reset(reset),
    .core_we(core_we), .core_waddr(core_waddr), .core_wdata(core_wdata),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .core_stall(core_stall), .init_done(init_done),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic core(input logic we, input logic [4:0] a, input logic [31:0] d);
    core_we = we; core_waddr = a; core_wdata = d;
  endtask

  task automatic dbg(input logic rq, input logic [4:0] a, input logic [31:0] d);
    dbg_req = rq; dbg_addr = a; dbg_wdata = d;
  endtask

  // Call at the negedge where the sweep's first cycle is visible; checks the first n cycles.
  task automatic sweep(input int n);
    for (int i = 1; i <= n; i++) begin
      #1;
      check($sformatf("sweep%0d_we", i),   32'(rf_we), 32'd1);
      check($sformatf("sweep%0d_addr", i), 32'(rf_waddr), 32'(i));
      check($sformatf("sweep%0d_data", i), rf_wdata, 32'd0);
      check($sformatf("sweep%0d_stall", i), 32'(core_stall), 32'd1);
      check($sformatf("sweep%0d_done", i), 32'(init_done), 32'd0);
      check($sformatf("sweep%0d_ack", i),  32'(dbg_ack), 32'd0);
      if (i != n) cyc();
    end
  endtask

  initial begin
    core(1'b1, 5'd5, 32'h1111_1111);
    repeat (2) cyc();
    #1;
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_stall", 32'(core_stall), 32'd1);
    check("rst_ack", 32'(dbg_ack), 32'd0);
    check("rst_done", 32'(init_done), 32'd0);
    core(1'b0, 5'd0, 32'd0);

`ifdef RF_INIT_SWEEP_EN
    // Partial sweep, reset at cycle 10, then a full restarted sweep with debug held (must be ignored).
    cyc(); reset = 1'b1;
    sweep(9);
    cyc(); #1; check("mid_addr10", 32'(rf_waddr), 32'd10);
    reset = 1'b0; #1;
    check("mid_rst_we", 32'(rf_we), 32'd0);
    check("mid_rst_done", 32'(init_done), 32'd0);
    cyc(); reset = 1'b1; dbg(1'b1, 5'd7, 32'hCAFE_0000);
    sweep(31);
    cyc(); dbg(1'b0, 5'd0, 32'd0);
    #1;
    check("run_done", 32'(init_done), 32'd1);
    check("run_ack0", 32'(dbg_ack), 32'd0);
`else
    cyc(); reset = 1'b1; #1;
    check("run_done", 32'(init_done), 32'd1);
    check("run_idle_we", 32'(rf_we), 32'd0);
    check("run_idle_stall", 32'(core_stall), 32'd0);
`endif

    // Core write, no debug.
    cyc(); core(1'b1, 5'd5, 32'hDEAD_BEEF); #1;
    check("core_we", 32'(rf_we), 32'd1);
    check("core_addr", 32'(rf_waddr), 32'd5);
    check("core_data", rf_wdata, 32'hDEAD_BEEF);
    check("core_stall", 32'(core_stall), 32'd0);

    // Debug write with core idle; request held through ack cycle.
    cyc(); core(1'b0, 5'd0, 32'd0); dbg(1'b1, 5'd7, 32'h1234_5678); #1;
    check("dbg_we", 32'(rf_we), 32'd1);
    check("dbg_addr", 32'(rf_waddr), 32'd7);
    check("dbg_data", rf_wdata, 32'h1234_5678);
    check("dbg_ack_early", 32'(dbg_ack), 32'd0);
    cyc(); #1;
    check("dbg_ack", 32'(dbg_ack), 32'd1);
    check("dbg_no_rewrite", 32'(rf_we), 32'd0);
    cyc(); dbg(1'b0, 5'd0, 32'd0); #1;
    check("dbg_ack_drop", 32'(dbg_ack), 32'd0);

    // Starvation: 4 core wins, then forced debug with stall.
    cyc(); core(1'b1, 5'd3, 32'h0000_0033); dbg(1'b1, 5'd9, 32'hA5A5_A5A5);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("starve%0d_addr", k), 32'(rf_waddr), 32'd3);
      check($sformatf("starve%0d_stall", k), 32'(core_stall), 32'd0);
      cyc();
    end
    #1;
    check("force_we", 32'(rf_we), 32'd1);
    check("force_addr", 32'(rf_waddr), 32'd9);
    check("force_data", rf_wdata, 32'hA5A5_A5A5);
    check("force_stall", 32'(core_stall), 32'd1);
    cyc(); #1;
    check("force_ack", 32'(dbg_ack), 32'd1);
    check("resume_addr", 32'(rf_waddr), 32'd3);
    check("resume_stall", 32'(core_stall), 32'd0);
    cyc(); core(1'b0, 5'd0, 32'd0); dbg(1'b0, 5'd0, 32'd0); #1;
    check("force_ack_drop", 32'(dbg_ack), 32'd0);

    // Core to x0 is idle: debug wins at once, no stall.
    cyc(); core(1'b1, 5'd0, 32'hFFFF_0000); dbg(1'b1, 5'd2, 32'h1); #1;
    check("x0core_addr", 32'(rf_waddr), 32'd2);
    check("x0core_data", rf_wdata, 32'h1);
    check("x0core_stall", 32'(core_stall), 32'd0);
    cyc(); core(1'b0, 5'd0, 32'd0); dbg(1'b1, 5'd0, 32'hFFFF_FFFF); #1;
    check("x0core_ack", 32'(dbg_ack), 32'd1);
    check("x0core_ackcyc_we", 32'(rf_we), 32'd0);
    cyc(); #1;
    check("x0dbg_we", 32'(rf_we), 32'd0);
    check("x0dbg_stall", 32'(core_stall), 32'd0);
    cyc(); dbg(1'b0, 5'd0, 32'd0); #1;
    check("x0dbg_ack", 32'(dbg_ack), 32'd1);
    cyc(); #1;
    check("x0dbg_ack_drop", 32'(dbg_ack), 32'd0);

    // Reset during a pending (losing) debug request.
    cyc(); core(1'b1, 5'd4, 32'h44); dbg(1'b1, 5'd6, 32'h66); #1;
    check("pend_addr", 32'(rf_waddr), 32'd4);
    cyc(); reset = 1'b0; #1;
    check("pend_rst_we", 32'(rf_we), 32'd0);
    check("pend_rst_stall", 32'(core_stall), 32'd1);
    check("pend_rst_ack", 32'(dbg_ack), 32'd0);
    cyc(); core(1'b0, 5'd0, 32'd0); reset = 1'b1;
`ifdef RF_INIT_SWEEP_EN
    sweep(31);
    cyc();
`endif
    #1;
    check("rearb_addr", 32'(rf_waddr), 32'd6);
    check("rearb_we", 32'(rf_we), 32'd1);
    cyc(); dbg(1'b0, 5'd0, 32'd0); #1;
    check("rearb_ack", 32'(dbg_ack), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
